result_display: RTL
===================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter Width, default 4, meaning: magnitude width of the subtraction result; supported range 4..8.
REQ-002 Parameter REFRESH_DIV, default 65536, meaning: clock cycles per display digit slot; minimum 2.
REQ-003 clk  input  1  meaning: the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  meaning: asynchronous, active-high reset.
REQ-005 load  input  1  meaning: one-cycle strobe that captures resta_end and borrow.
REQ-006 resta_end  input  Width  meaning: unsigned result magnitude from the subtraction stage.
REQ-007 borrow  input  1  meaning: 1 = result non-negative (a >= b); 0 = result negative.
REQ-008 an  output  4  meaning: active-low one-hot digit enable; an[3] is the leftmost digit.
REQ-009 seg  output  7  meaning: active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 busy  output  1  meaning: high while a conversion is in progress.
REQ-011 done  output  1  meaning: one-cycle pulse when new digits are on display.

Function
REQ-012 The FSM SHALL have three states: IDLE (nothing loaded), CONV (binary-to-BCD), SHOW (digits valid).
REQ-013 load SHALL be accepted in IDLE or SHOW, including the cycle in which done is high; operands are captured at that edge (edge k) and the state moves to CONV.
REQ-014 load in CONV SHALL be ignored, with no effect on the conversion in progress.
REQ-015 CONV SHALL perform one shift-add-3 (double-dabble) step per cycle into a 12-bit BCD register (hundreds, tens, units), for exactly Width steps.
REQ-016 At edge k+Width, the BCD result and sign SHALL transfer to the display registers and the state SHALL move to SHOW.
REQ-017 busy SHALL be high for cycles k+1 through k+Width, and done SHALL be high only in cycle k+Width+1.
REQ-018 A refresh counter SHALL free-run in every state; every REFRESH_DIV cycles the digit index SHALL advance 0->1->2->3->0, with an = ~(1 << index).
REQ-019 Digit mapping: index 0 = units, 1 = tens, 2 = hundreds, 3 = sign.
REQ-020 The sign digit SHALL show minus (seg=0111111) when borrow=0 and magnitude != 0; otherwise it SHALL be blank (1111111).
REQ-021 A negative zero (borrow=0, resta_end=0) SHALL display as plain 0 with no minus.
REQ-022 BCD digit encodings, in g..a order, SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 In IDLE, seg SHALL be 1111111 for every digit slot, while an continues to scan.
REQ-024 In CONV, the previously shown digits, if any, SHALL remain displayed until the edge in REQ-016.

Reset
REQ-025 rst=1 SHALL, asynchronously, force state=IDLE, refresh counter=0, digit index=0 (an=1110), seg=1111111, busy=0, done=0, and clear all BCD and display registers.
REQ-026 Reset during CONV SHALL abort the conversion; done SHALL NOT pulse for the aborted load.
REQ-027 After rst deasserts, the block SHALL remain in IDLE until the next load.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN: when defined, the hundreds digit SHALL be blank when 0, and the tens digit SHALL be blank when both hundreds and tens are 0; units always display, and the sign digit is unaffected.
REQ-029 When LEADING_ZERO_BLANK_EN is undefined, all three BCD digits SHALL always display, including leading zeros.

Verification (Width=4, REFRESH_DIV=4 unless stated)
REQ-030 Load 9 with borrow=1 at edge k -> busy high for cycles k+1..k+4, done high in cycle k+5; slots show units 0010000, tens 1000000, hundreds 1000000, sign 1111111.
REQ-031 Load 7 with borrow=0 -> sign slot 0111111 and units 1111000; load 0 with borrow=0 -> sign slot 1111111 and units 1000000.
REQ-032 Width=8 instance, load 255 with borrow=1 -> done 9 cycles after the load edge; digits show 2, 5, 5.
REQ-033 Load 3, then load 12 two cycles later -> the second load is ignored and 3 is displayed; load 12 in the done cycle -> accepted and 12 is displayed.
REQ-034 Assert rst in the 2nd CONV cycle -> immediately an=1110, seg=1111111, busy=0; no done pulse follows; the display stays blank.
REQ-035 With LEADING_ZERO_BLANK_EN defined, load 5 with borrow=1 -> hundreds and tens slots 1111111, units 0010010.

Source files
------------

// File: rtl/result_display.sv
// Signed subtraction-result display: double-dabble conversion into BCD, then a
// multiplexed 4-digit seven-segment scan. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module result_display #(
    parameter int Width       = 4,
    parameter int REFRESH_DIV = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] resta_end,
    input  logic             borrow,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             busy,
    output logic             done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(Width);
    localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(Width - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;
    localparam logic [6:0]    SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    state_t           state_reg, state_next;
    logic [Width-1:0] bin_reg;
    logic [11:0]      bcd_reg, bcd_adj, bcd_step, disp_bcd_reg;
    logic [SW-1:0]    step_reg;
    logic [CW-1:0]    ref_cnt_reg;
    logic [1:0]       digit_idx_reg;
    logic             neg_reg, disp_neg_reg, disp_valid_reg, done_reg;
    logic             accept, last_step;
    logic [3:0]       units, tens, hund;
    logic             tens_blank, hund_blank;

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign accept    = load && (state_reg != CONV);
    assign last_step = (state_reg == CONV) && (step_reg == STEP_LAST);

    // Add-3 correction on every BCD digit of 5 or more before the shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_step = (bcd_adj << 1) | {11'b0, bin_reg[Width-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (step_reg == STEP_LAST) state_next = SHOW;
            SHOW:    if (load) state_next = CONV;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg        <= '0;
            bcd_reg        <= '0;
            step_reg       <= '0;
            neg_reg        <= 1'b0;
            disp_bcd_reg   <= '0;
            disp_neg_reg   <= 1'b0;
            disp_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= last_step;
            if (accept) begin
                bin_reg  <= resta_end;
                bcd_reg  <= '0;
                step_reg <= '0;
                // A negative zero is shown as plain zero, so the sign needs a nonzero magnitude.
                neg_reg  <= ~borrow & (|resta_end);
            end else if (state_reg == CONV) begin
                bin_reg  <= bin_reg << 1;
                bcd_reg  <= bcd_step;
                step_reg <= step_reg + 1'b1;
                if (last_step) begin
                    disp_bcd_reg   <= bcd_step;
                    disp_neg_reg   <= neg_reg;
                    disp_valid_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_reg   <= '0;
            digit_idx_reg <= 2'd0;
        end else if (ref_cnt_reg == REF_LAST) begin
            ref_cnt_reg   <= '0;
            digit_idx_reg <= digit_idx_reg + 2'd1;
        end else begin
            ref_cnt_reg <= ref_cnt_reg + 1'b1;
        end
    end

    assign units = disp_bcd_reg[3:0];
    assign tens  = disp_bcd_reg[7:4];
    assign hund  = disp_bcd_reg[11:8];

`ifdef LEADING_ZERO_BLANK_EN
    assign hund_blank = (hund == 4'd0);
    assign tens_blank = (hund == 4'd0) && (tens == 4'd0);
`else
    assign hund_blank = 1'b0;
    assign tens_blank = 1'b0;
`endif

    always_comb begin
        busy = (state_reg == CONV);
        done = done_reg;
        an   = ~(4'b0001 << digit_idx_reg);
        seg  = SEG_BLANK;
        if (state_reg != IDLE && disp_valid_reg) begin
            case (digit_idx_reg)
                2'd0:    seg = seven_seg(units);
                2'd1:    seg = tens_blank ? SEG_BLANK : seven_seg(tens);
                2'd2:    seg = hund_blank ? SEG_BLANK : seven_seg(hund);
                default: seg = disp_neg_reg ? SEG_MINUS : SEG_BLANK;
            endcase
        end
    end

endmodule
